// File: rtl/x_debounce_pkg.sv
// Shared definitions for the x input conditioner and the state machine it feeds.
// State encodings are fixed so downstream debug views decode them the same way.
package x_debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b11,
    WAIT_LO   = 2'b10
  } db_state_t;

  localparam int DEBOUNCE_DEFAULT = 4;

endpackage

// File: rtl/x_debounce_sync2.sv
// Two-flop synchronizer for an asynchronous level; reusable for other async inputs.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/x_debounce.sv
// Debounces raw_in into a clean x level with one-cycle rise/fall strobes.
// A new level must be seen on DEBOUNCE_CYCLES consecutive synchronized samples.
module x_debounce
  import x_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic x,
  output logic x_rise,
  output logic x_fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit               ONE_SHOT = (DEBOUNCE_CYCLES == 1);

  db_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             s;

  sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (raw_in),
    .q     (s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= STABLE_LO;
      cnt    <= '0;
      x      <= 1'b0;
      x_rise <= 1'b0;
      x_fall <= 1'b0;
    end else begin
      x_rise <= 1'b0;
      x_fall <= 1'b0;
      case (state)
        STABLE_LO: if (s) begin
          // The first opposite sample already counts as observation #1.
          if (ONE_SHOT) begin
            state  <= STABLE_HI;
            x      <= 1'b1;
            x_rise <= 1'b1;
          end else begin
            state <= WAIT_HI;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT_HI: begin
          if (!s) begin
            state <= STABLE_LO;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state  <= STABLE_HI;
            cnt    <= '0;
            x      <= 1'b1;
            x_rise <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STABLE_HI: if (!s) begin
          if (ONE_SHOT) begin
            state  <= STABLE_LO;
            x      <= 1'b0;
            x_fall <= 1'b1;
          end else begin
            state <= WAIT_LO;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT_LO: begin
          if (s) begin
            state <= STABLE_HI;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state  <= STABLE_LO;
            cnt    <= '0;
            x      <= 1'b0;
            x_fall <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= STABLE_LO;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state == WAIT_HI) || (state == WAIT_LO);

endmodule
